uart_fifo_core: RTL and testbench
=================================

Name: uart_fifo_core

Overview:
Parametrised UART core that succeeds the fixed 9600 b/s rcvr/txmit pair behind the Atlys USB-UART bridge. It has an internal 16x baud generator, configurable frame format (data bits, parity, stop bits) and a receive FIFO. Valid/ready byte interfaces connect it to host logic such as the genusbuart controllers. A compile-time echo (loopback) mode replaces the external echo glue.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BAUD, 9600, line rate in b/s; DIV = (CLK_HZ + 8*BAUD)/(16*BAUD), must be >= 2
DATA_BITS, 8, data bits per frame, 5..8
PARITY, 0, 0 none, 1 odd, 2 even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, RX FIFO entries, power of two, >= 2

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous assert, active-low
RXD  in  1  serial input, asynchronous to CLK, idle high
TXD  out  1  serial output, idle high
tx_data  in  8  byte to send, bits above DATA_BITS ignored
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter accepts a byte this cycle
rx_data  out  8  FIFO head, zero-extended above DATA_BITS
rx_valid  out  1  FIFO not empty
rx_ready  in  1  host pops head when rx_valid & rx_ready
rx_count  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy
par_err  out  1  one-CLK pulse: parity mismatch, byte discarded
frame_err  out  1  one-CLK pulse: stop bit sampled 0, byte discarded
overrun  out  1  one-CLK pulse: good byte received while FIFO full, byte dropped

Behaviour:
- Reset values while RST=0: TXD=1, tx_ready=0, rx_valid=0, rx_data=0, rx_count=0, all error pulses 0, FIFO emptied, baud counter 0, both FSMs IDLE. tx_ready rises 1 CLK after RST deasserts.
- Reset asserted mid-frame aborts the frame: TXD returns high at once and no partial byte is stored.
- Baud tick: counter runs 0..DIV-1 and emits a one-CLK tick at DIV-1. One bit period = 16 ticks = 16*DIV CLKs.
- RX sync: RXD passes through a 2-FF synchroniser (reset value 1). All RX logic uses the synchronised signal.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START when the line is sampled low on a tick.
  - START: after 8 ticks, if the line is still low go to DATA; otherwise it is a glitch and the FSM returns to IDLE.
  - DATA: sample every 16 ticks, LSB first, DATA_BITS samples.
  - PAR (only when PARITY != 0): one sample, checked against the configured parity.
  - STOP: one sample. If 0, pulse frame_err, then stay in STOP until the line is high before returning to IDLE (break-safe). If 1, the byte is complete.
  - Completed byte: on parity error pulse par_err and discard. Otherwise push to the FIFO on the same CLK as the stop sample, or pulse overrun if the FIFO is full.
  - A second stop bit is never checked by RX.
- RX FIFO: first-word-fall-through.
  - rx_data/rx_valid reflect the head combinationally from registered state.
  - A pushed byte is visible 1 CLK after the push.
  - Push and pop in the same CLK when full: both succeed, count unchanged, no overrun.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, PAR, STOP.
  - tx_ready=1 only in IDLE. A byte is accepted on tx_valid & tx_ready.
  - TXD goes low 1 CLK after acceptance. The bit counter is aligned to the accept, not to the free-running tick phase; each bit lasts exactly 16*DIV CLKs.
  - Frame order: start 0, data LSB first, parity if enabled, STOP_BITS high bits.
  - Back-to-back frames: tx_ready returns in the CLK after the last stop bit ends.
- Parity: odd parity makes the total count of ones (data + parity) odd; even parity makes it even.

Optional Feature:
- Macro: UART_FIFO_LOOPBACK_EN.
- With the macro defined, the core has an extra port "loopback in 1".
  - When loopback=1, the TX source is the RX FIFO head, and the TX accept pops the FIFO.
  - Host-side tx_ready and rx_valid are forced 0; tx_valid and rx_ready are ignored.
  - Changing loopback affects only the next TX accept or FIFO pop; a frame in flight completes.
- Without the macro: the port is absent and the core behaves as loopback=0.

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - RX and TX state enums;
  - a constant function computing DIV from CLK_HZ and BAUD;
  - a constant function computing the occupancy width.
- Sub-module uart_rx_fifo (parametrised by width and depth) carries the FIFO and its count. Baud generator, RX FSM and TX FSM stay in uart_fifo_core.

Test Plan:
All scenarios use CLK_HZ=50_000_000 and BAUD=9600, so DIV=326 and one bit = 5216 CLKs.
- 8N1, host sends 0xA5 -> TXD sequence 0,1,0,1,0,0,1,0,1,1, each bit 5216 CLKs; tx_ready low for 52160 CLKs, then high.
- Drive an RXD frame of 0x3C at 9600 b/s (±2% skew) -> rx_valid=1 within 3 CLKs after mid-stop, rx_data=0x3C, rx_count=1; pop clears rx_valid.
- Low pulse on RXD of 3*326 CLKs -> no byte, no error pulses, rx_count stays 0.
- FIFO_DEPTH=4, five frames 0x01..0x05 with no pops -> rx_count=4, a single overrun pulse, pops return 0x01..0x04. A push coinciding with a pop while full leaves no overrun.
- PARITY=2, frame with data 0x01 and parity bit 0 -> par_err pulse, nothing stored. A next frame with stop=0 -> frame_err pulse; the RX FSM re-arms only after RXD goes high.
- Macro defined, loopback=1, RX 0x55 then 0xAA -> TXD echoes 0x55 then 0xAA, rx_valid stays 0 throughout, rx_count returns to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and sizing helpers for the uart_fifo_core slice.
package uart_pkg;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxPar, RxStop} rx_state_e;
    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxPar, TxStop} tx_state_e;

    // Rounded CLK_HZ / (16 * BAUD): clocks per oversampling tick.
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return (clk_hz + 8 * baud) / (16 * baud);
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with occupancy count; power-of-two depth.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_data,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_data,
    output logic                          o_valid,
    output logic                          o_full,
    output logic [count_width(DEPTH)-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop & o_valid;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count   = r_count;

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo_core.sv
// UART with 16x baud generator, configurable frame and RX FIFO.
// Define UART_FIFO_LOOPBACK_EN to add i_loopback (echo RX FIFO into TX).
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 100_000_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = PAR_NONE,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
`ifdef UART_FIFO_LOOPBACK_EN
    input  logic                               i_loopback,
`endif
    input  logic                               i_rxd,
    output logic                               o_txd,
    input  logic [7:0]                         i_tx_data,
    input  logic                               i_tx_valid,
    output logic                               o_tx_ready,
    output logic [7:0]                         o_rx_data,
    output logic                               o_rx_valid,
    input  logic                               i_rx_ready,
    output logic [count_width(FIFO_DEPTH)-1:0] o_rx_count,
    output logic                               o_par_err,
    output logic                               o_frame_err,
    output logic                               o_overrun
);

    localparam int unsigned DIV      = calc_div(CLK_HZ, BAUD);
    localparam int unsigned DIV_W    = $clog2(DIV);
    localparam int unsigned BIT_CLKS = 16 * DIV;
    localparam int unsigned TXC_W    = $clog2(BIT_CLKS);

    logic w_loop;
`ifdef UART_FIFO_LOOPBACK_EN
    assign w_loop = i_loopback;
`else
    assign w_loop = 1'b0;
`endif

    logic [DIV_W-1:0]     r_baud;
    logic                 w_tick;
    logic                 r_rxd_meta, r_rxd_sync;
    rx_state_e            r_rx_state;
    logic [3:0]           r_rx_tick;
    logic [2:0]           r_rx_bit;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic                 r_rx_par, r_rx_brk;
    logic                 r_par_err, r_frame_err, r_overrun;
    logic                 w_par_bad, w_push, w_pop;
    logic [DATA_BITS-1:0] w_fifo_data;
    logic                 w_fifo_valid, w_fifo_full;
    tx_state_e            r_tx_state;
    logic [TXC_W-1:0]     r_tx_cnt;
    logic [2:0]           r_tx_bit;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par, r_txd, r_tx_ready;
    logic                 w_tx_valid, w_tx_accept;
    logic [DATA_BITS-1:0] w_tx_byte;

    assign w_tick = (r_baud == DIV_W'(DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_baud     <= '0;
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_baud     <= w_tick ? '0 : r_baud + 1'b1;
            r_rxd_meta <= i_rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    // XOR of data and parity is 1 when the total number of ones is odd.
    assign w_par_bad = (PARITY == PAR_ODD)  ? ~(^r_rx_shift ^ r_rx_par) :
                       (PARITY == PAR_EVEN) ?  (^r_rx_shift ^ r_rx_par) : 1'b0;
    assign w_push    = (r_rx_state == RxStop) & w_tick & (r_rx_tick == 4'd15) & ~r_rx_brk &
                       r_rxd_sync & ~w_par_bad;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_state  <= RxIdle;
            r_rx_tick   <= '0;
            r_rx_bit    <= '0;
            r_rx_shift  <= '0;
            r_rx_par    <= 1'b0;
            r_rx_brk    <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_par_err   <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= w_push & w_fifo_full & ~w_pop;
            if (w_tick) begin
                case (r_rx_state)
                    RxIdle: begin
                        if (!r_rxd_sync) begin
                            r_rx_state <= RxStart;
                            r_rx_tick  <= '0;
                        end
                    end
                    RxStart: begin
                        if (r_rx_tick == 4'd7) begin
                            r_rx_tick  <= '0;
                            r_rx_bit   <= '0;
                            r_rx_state <= r_rxd_sync ? RxIdle : RxData;
                        end else begin
                            r_rx_tick <= r_rx_tick + 4'd1;
                        end
                    end
                    RxData: begin
                        if (r_rx_tick == 4'd15) begin
                            r_rx_tick  <= '0;
                            r_rx_shift <= {r_rxd_sync, r_rx_shift[DATA_BITS-1:1]};
                            if (r_rx_bit == 3'(DATA_BITS - 1)) begin
                                r_rx_state <= (PARITY != PAR_NONE) ? RxPar : RxStop;
                            end else begin
                                r_rx_bit <= r_rx_bit + 3'd1;
                            end
                        end else begin
                            r_rx_tick <= r_rx_tick + 4'd1;
                        end
                    end
                    RxPar: begin
                        if (r_rx_tick == 4'd15) begin
                            r_rx_tick  <= '0;
                            r_rx_par   <= r_rxd_sync;
                            r_rx_state <= RxStop;
                        end else begin
                            r_rx_tick <= r_rx_tick + 4'd1;
                        end
                    end
                    RxStop: begin
                        // After a bad stop bit, hold here until the line is released.
                        if (r_rx_brk) begin
                            if (r_rxd_sync) begin
                                r_rx_brk   <= 1'b0;
                                r_rx_state <= RxIdle;
                            end
                        end else if (r_rx_tick == 4'd15) begin
                            r_rx_tick <= '0;
                            if (!r_rxd_sync) begin
                                r_frame_err <= 1'b1;
                                r_rx_brk    <= 1'b1;
                            end else begin
                                r_par_err  <= w_par_bad;
                                r_rx_state <= RxIdle;
                            end
                        end else begin
                            r_rx_tick <= r_rx_tick + 4'd1;
                        end
                    end
                    default: r_rx_state <= RxIdle;
                endcase
            end
        end
    end

    assign w_tx_valid  = w_loop ? w_fifo_valid : i_tx_valid;
    assign w_tx_byte   = w_loop ? w_fifo_data : i_tx_data[DATA_BITS-1:0];
    assign w_tx_accept = r_tx_ready & w_tx_valid;
    assign w_pop       = w_loop ? w_tx_accept : i_rx_ready;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (r_rx_shift),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_valid (w_fifo_valid),
        .o_full  (w_fifo_full),
        .o_count (o_rx_count)
    );

    // Bit timing restarts at accept, independent of the RX tick phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_state <= TxIdle;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_txd      <= 1'b1;
            r_tx_ready <= 1'b0;
        end else if (r_tx_state == TxIdle) begin
            r_txd <= 1'b1;
            if (w_tx_accept) begin
                r_tx_state <= TxStart;
                r_tx_ready <= 1'b0;
                r_txd      <= 1'b0;
                r_tx_cnt   <= '0;
                r_tx_shift <= w_tx_byte;
                r_tx_par   <= (PARITY == PAR_ODD) ? ~^w_tx_byte : ^w_tx_byte;
            end else begin
                r_tx_ready <= 1'b1;
            end
        end else if (r_tx_cnt != TXC_W'(BIT_CLKS - 1)) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end else begin
            r_tx_cnt <= '0;
            case (r_tx_state)
                TxStart: begin
                    r_tx_state <= TxData;
                    r_tx_bit   <= '0;
                    r_txd      <= r_tx_shift[0];
                end
                TxData: begin
                    if (r_tx_bit == 3'(DATA_BITS - 1)) begin
                        r_tx_bit   <= '0;
                        r_tx_state <= (PARITY != PAR_NONE) ? TxPar : TxStop;
                        r_txd      <= (PARITY != PAR_NONE) ? r_tx_par : 1'b1;
                    end else begin
                        r_tx_bit   <= r_tx_bit + 3'd1;
                        r_tx_shift <= r_tx_shift >> 1;
                        r_txd      <= r_tx_shift[1];
                    end
                end
                TxPar: begin
                    r_tx_state <= TxStop;
                    r_txd      <= 1'b1;
                end
                TxStop: begin
                    if (r_tx_bit == 3'(STOP_BITS - 1)) begin
                        r_tx_state <= TxIdle;
                        r_tx_ready <= 1'b1;
                    end else begin
                        r_tx_bit <= r_tx_bit + 3'd1;
                    end
                    r_txd <= 1'b1;
                end
                default: r_tx_state <= TxIdle;
            endcase
        end
    end

    always_comb begin
        o_rx_data                = '0;
        o_rx_data[DATA_BITS-1:0] = w_fifo_data;
    end

    assign o_txd       = r_txd;
    assign o_tx_ready  = r_tx_ready & ~w_loop;
    assign o_rx_valid  = w_fifo_valid & ~w_loop;
    assign o_par_err   = r_par_err;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_fifo_core.sv
// Self-checking bench for uart_fifo_core: 8E2 frames, 4-entry FIFO, DIV=4 (64 CLKs per bit).
module tb_uart_fifo_core;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 15625;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned BITC   = 64;
    localparam int unsigned NBITS  = 12;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_rxd;
    logic             o_txd;
    logic [7:0]       i_tx_data;
    logic             i_tx_valid;
    logic             o_tx_ready;
    logic [7:0]       o_rx_data;
    logic             o_rx_valid;
    logic             i_rx_ready;
    logic [CNT_W-1:0] o_rx_count;
    logic             o_par_err, o_frame_err, o_overrun;
    logic             tb_loopback = 1'b0;

    uart_fifo_core #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DATA_BITS  (8),
        .PARITY     (2),
        .STOP_BITS  (2),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
`ifdef UART_FIFO_LOOPBACK_EN
        .i_loopback  (tb_loopback),
`endif
        .i_rxd       (i_rxd),
        .o_txd       (o_txd),
        .i_tx_data   (i_tx_data),
        .i_tx_valid  (i_tx_valid),
        .o_tx_ready  (o_tx_ready),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .i_rx_ready  (i_rx_ready),
        .o_rx_count  (o_rx_count),
        .o_par_err   (o_par_err),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int n_par = 0, n_frame = 0, n_ovr = 0, n_lb_valid = 0, n_lb_ready = 0;
    int exp_par = 0, exp_frame = 0, exp_ovr = 0;
    logic [7:0] q[$];
    bit         coinc_en = 1'b0;
    bit         coinc_done = 1'b0;
    logic [7:0] coinc_head = 8'h00;

    always @(negedge i_clk) begin
        if (o_par_err)                 n_par      <= n_par + 1;
        if (o_frame_err)               n_frame    <= n_frame + 1;
        if (o_overrun)                 n_ovr      <= n_ovr + 1;
        if (tb_loopback && o_rx_valid) n_lb_valid <= n_lb_valid + 1;
        if (tb_loopback && o_tx_ready) n_lb_ready <= n_lb_ready + 1;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tx_frame(input logic [7:0] b);
        logic [NBITS-1:0] bits;
        int n;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[1+k] = b[k];
        bits[9]  = ^b;
        bits[10] = 1'b1;
        bits[11] = 1'b1;
        n = 0;
        while (!o_tx_ready && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        check_eq("tx_ready_wait", o_tx_ready, 1);
        i_tx_data  = b;
        i_tx_valid = 1'b1;
        @(negedge i_clk);
        i_tx_valid = 1'b0;
        i_tx_data  = $urandom;
        for (int i = 0; i <= NBITS * BITC; i++) begin
            if (i < NBITS * BITC && (i % BITC == 0 || i % BITC == BITC - 1))
                check_eq($sformatf("tx_%02h_bit%0d_at%0d", b, i / BITC, i % BITC), o_txd,
                         bits[i/BITC]);
            if (i == 0 || i == NBITS * BITC - 1) check_eq("tx_ready_busy", o_tx_ready, 0);
            if (i == NBITS * BITC) begin
                check_eq("tx_ready_back", o_tx_ready, 1);
                check_eq("tx_idle_high", o_txd, 1);
            end else begin
                @(negedge i_clk);
            end
        end
    endtask

    task automatic rx_step();
        @(negedge i_clk);
        // Time a pop to land on the very cycle a byte is pushed.
        if (coinc_en && !coinc_done && dut.w_push) begin
            i_rx_ready = 1'b1;
            coinc_done = 1'b1;
            coinc_head = o_rx_data;
        end else begin
            i_rx_ready = 1'b0;
        end
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit bad_par, input bit stop_val,
                            input int brk_clks);
        logic [10:0] bits;
        int per;
        per = 63 + int'($urandom_range(0, 2));
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[1+k] = b[k];
        bits[9]  = ^b ^ bad_par;
        bits[10] = stop_val;
        for (int k = 0; k < 11; k++) begin
            i_rxd = bits[k];
            repeat (per) rx_step();
        end
        if (!stop_val) repeat (brk_clks) rx_step();
        i_rxd = 1'b1;
        repeat (48) rx_step();
    endtask

    task automatic rx_model(input logic [7:0] b, input bit bad_par, input bit stop_val,
                            input bit coinc);
        if (!stop_val) begin
            exp_frame++;
        end else if (bad_par) begin
            exp_par++;
        end else if (q.size() == DEPTH) begin
            if (coinc) begin
                check_eq("coinc_pop_done", coinc_done, 1);
                check_eq("coinc_head", coinc_head, q[0]);
                void'(q.pop_front());
                q.push_back(b);
            end else begin
                exp_ovr++;
            end
        end else begin
            q.push_back(b);
        end
    endtask

    task automatic check_rx(input string tag);
        check_eq({tag, "_count"}, o_rx_count, q.size());
        check_eq({tag, "_valid"}, o_rx_valid, q.size() != 0);
        check_eq({tag, "_data"}, o_rx_data, q.size() != 0 ? q[0] : 8'h00);
        check_eq({tag, "_par_err"}, n_par, exp_par);
        check_eq({tag, "_frame_err"}, n_frame, exp_frame);
        check_eq({tag, "_overrun"}, n_ovr, exp_ovr);
    endtask

    task automatic rx_send(input string tag, input logic [7:0] b, input bit bad_par,
                           input bit stop_val, input int brk_clks, input bit coinc);
        coinc_en   = coinc;
        coinc_done = 1'b0;
        rx_frame(b, bad_par, stop_val, brk_clks);
        coinc_en = 1'b0;
        rx_model(b, bad_par, stop_val, coinc);
        check_rx(tag);
    endtask

    task automatic pop_one();
        logic [7:0] e;
        e = q.pop_front();
        check_eq("pop_valid", o_rx_valid, 1);
        check_eq("pop_data", o_rx_data, e);
        i_rx_ready = 1'b1;
        @(negedge i_clk);
        i_rx_ready = 1'b0;
    endtask

`ifdef UART_FIFO_LOOPBACK_EN
    task automatic tx_decode(output logic [7:0] d);
        int n;
        n = 0;
        while (o_txd && n < 6000) begin
            @(negedge i_clk);
            n++;
        end
        check_eq("lb_start_seen", o_txd, 0);
        repeat (BITC / 2) @(negedge i_clk);
        check_eq("lb_start_mid", o_txd, 0);
        for (int k = 0; k < 8; k++) begin
            repeat (BITC) @(negedge i_clk);
            d[k] = o_txd;
        end
        repeat (BITC) @(negedge i_clk);
        check_eq("lb_parity", o_txd, ^d);
        repeat (BITC) @(negedge i_clk);
        check_eq("lb_stop1", o_txd, 1);
        repeat (BITC) @(negedge i_clk);
        check_eq("lb_stop2", o_txd, 1);
    endtask
`endif

    initial begin
        logic [7:0] b;
        bit bad;
        i_rst_n    = 1'b0;
        i_rxd      = 1'b1;
        i_tx_data  = 8'h00;
        i_tx_valid = 1'b0;
        i_rx_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        check_eq("rst_txd", o_txd, 1);
        check_eq("rst_tx_ready", o_tx_ready, 0);
        check_eq("rst_rx_valid", o_rx_valid, 0);
        check_eq("rst_rx_data", o_rx_data, 0);
        check_eq("rst_rx_count", o_rx_count, 0);
        check_eq("rst_errs", {o_par_err, o_frame_err, o_overrun}, 0);
        i_rst_n = 1'b1;
        check_eq("rel_tx_ready_0", o_tx_ready, 0);
        @(negedge i_clk);
        check_eq("rel_tx_ready_1", o_tx_ready, 1);

        // TX: fixed byte then random bytes at random phase.
        tx_frame(8'hA5);
        for (int i = 0; i < 3; i++) begin
            repeat ($urandom_range(0, 7)) @(negedge i_clk);
            tx_frame(8'($urandom));
        end

        // RX basic receive and pop.
        rx_send("rx_3c", 8'h3C, 1'b0, 1'b1, 0, 1'b0);
        pop_one();
        check_eq("rx_3c_popped_valid", o_rx_valid, 0);
        check_eq("rx_3c_popped_count", o_rx_count, 0);

        // Short low glitch: ignored.
        i_rxd = 1'b0;
        repeat (12) rx_step();
        i_rxd = 1'b1;
        repeat (100) rx_step();
        check_rx("glitch");

        // Fill past depth, then a push coinciding with a pop while full.
        for (int i = 1; i <= 5; i++) rx_send($sformatf("fill_%0d", i), 8'(i), 1'b0, 1'b1, 0, 1'b0);
        rx_send("coinc", 8'h06, 1'b0, 1'b1, 0, 1'b1);
        while (q.size() != 0) pop_one();
        check_rx("drained");

        // Parity error, then framing error with a held break, then recovery.
        rx_send("par_bad", 8'h01, 1'b1, 1'b1, 0, 1'b0);
        rx_send("brk", 8'h81, 1'b0, 1'b0, 300, 1'b0);
        rx_send("rearm", 8'h7E, 1'b0, 1'b1, 0, 1'b0);
        pop_one();

        // Randomized RX traffic with random pops.
        for (int i = 0; i < 16; i++) begin
            b   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            rx_send($sformatf("rnd%0d", i), b, bad, 1'b1, 0, 1'b0);
            if (q.size() != 0 && $urandom_range(0, 1) == 1) pop_one();
        end

        // Reset mid-frame on both directions.
        tx_frame_start: begin
            i_tx_data  = 8'h0F;
            i_tx_valid = 1'b1;
            @(negedge i_clk);
            i_tx_valid = 1'b0;
        end
        i_rxd = 1'b0;
        repeat (64) @(negedge i_clk);
        i_rxd = 1'b1;
        repeat (64) @(negedge i_clk);
        i_rxd = 1'b0;
        repeat (100) @(negedge i_clk);
        #3 i_rst_n = 1'b0;
        #1;
        check_eq("midrst_txd", o_txd, 1);
        check_eq("midrst_tx_ready", o_tx_ready, 0);
        check_eq("midrst_count", o_rx_count, 0);
        q.delete();
        i_rxd = 1'b1;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (900) @(negedge i_clk);
        check_rx("after_midrst");
        check_eq("after_midrst_txd", o_txd, 1);
        check_eq("after_midrst_ready", o_tx_ready, 1);

`ifdef UART_FIFO_LOOPBACK_EN
        begin
            logic [7:0] got0, got1;
            tb_loopback = 1'b1;
            fork
                begin
                    rx_frame(8'h55, 1'b0, 1'b1, 0);
                    rx_frame(8'hAA, 1'b0, 1'b1, 0);
                end
                begin
                    tx_decode(got0);
                    tx_decode(got1);
                end
            join
            repeat (10) @(negedge i_clk);
            check_eq("lb_echo0", got0, 8'h55);
            check_eq("lb_echo1", got1, 8'hAA);
            check_eq("lb_count", o_rx_count, 0);
            check_eq("lb_rx_valid_seen", n_lb_valid, 0);
            check_eq("lb_tx_ready_seen", n_lb_ready, 0);
            tb_loopback = 1'b0;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
